// File: rtl/counter_seq.sv
// counter_seq: run controller for the tile counter; COUNTER_SEQ_IRQ_EN adds a sticky irq
module counter_seq #(
  parameter int BITS = 4,
  parameter int PRESCALE = 1,
  parameter logic [BITS-1:0] LIMIT_RST = {BITS{1'b1}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  input  logic [1:0]      cmd_op,
  input  logic [BITS-1:0] cmd_arg,
  output logic            cmd_ready,
  input  logic [BITS-1:0] count_i,
  output logic            cnt_clr,
  output logic            cnt_en,
  output logic            busy,
  output logic            done,
  output logic [1:0]      state_o,
  output logic            irq,
  input  logic            irq_clr
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  typedef enum logic [1:0] {IDLE, CLR, RUN, HOLD} state_t;
  state_t state, state_nx;
  logic [PW-1:0] pre;
  logic [BITS-1:0] limit;
  logic periodic, acc, start, stop, load, term;
  assign acc = cmd_valid & cmd_ready;
  assign start = acc & ~cmd_op[1];
  assign stop = acc & (cmd_op == 2'b10);
  assign load = acc & (cmd_op == 2'b11);
  // limit-1 wraps, so a zero limit terminates after the full 2^BITS ticks
  assign term = cnt_en & (count_i == limit - BITS'(1));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = stop ? IDLE : start ? CLR : state == CLR ? RUN :
               term ? (periodic ? CLR : HOLD) : state;
  always_comb begin
    cmd_ready = state != CLR;
    cnt_clr = state == CLR;
    busy = state == CLR || state == RUN;
    cnt_en = state == RUN && pre == PW'(PRESCALE - 1);
    state_o = state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pre <= '0;
      limit <= LIMIT_RST;
      periodic <= 1'b0;
      done <= 1'b0;
    end else begin
      pre <= (state != RUN || cnt_en) ? '0 : pre + PW'(1);
      limit <= load ? cmd_arg : limit;
      periodic <= start ? cmd_op[0] : periodic;
      done <= term & ~stop;
    end
`ifdef COUNTER_SEQ_IRQ_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) irq <= 1'b0;
    else irq <= done | (irq & ~irq_clr);
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_counter_seq.sv
// tb_counter_seq: counter_seq at PRESCALE 2 and 1 against a cycle-schedule model
`timescale 1ns/1ps
module tb_counter_seq;
`ifdef COUNTER_SEQ_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, irq_clr = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_arg = 4'd0;
  logic [1:0] rdy, clr, en, busy, done, irq;
  logic [1:0][1:0] st;
  logic [1:0][3:0] cnt;
  int n_chk = 0, n_err = 0, cyc = 0;
  int en_n [2], done_n [2], nrdy_n [2], gap [2], last_done [2];
  always #5 clk = ~clk;
  counter_seq #(.BITS(4), .PRESCALE(2)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cmd_ready(rdy[0]), .count_i(cnt[0]), .cnt_clr(clr[0]), .cnt_en(en[0]), .busy(busy[0]),
    .done(done[0]), .state_o(st[0]), .irq(irq[0]), .irq_clr(irq_clr));
  counter_seq #(.BITS(4), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cmd_ready(rdy[1]), .count_i(cnt[1]), .cnt_clr(clr[1]), .cnt_en(en[1]), .busy(busy[1]),
    .done(done[1]), .state_o(st[1]), .irq(irq[1]), .irq_clr(irq_clr));
  // the 4-bit tile counters driven by each controller
  always @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else for (int i = 0; i < 2; i++) cnt[i] <= clr[i] ? 4'd0 : en[i] ? cnt[i] + 4'd1 : cnt[i];
  // model: an active run is d cycles past its clear; ticks at d = k*P, terminal at d = limit*P
  bit m_act [2], m_hold [2], m_per [2], m_done [2], m_irq [2];
  int m_d [2];
  logic [3:0] m_lim [2];
  bit acc, term;
  function automatic int span(int i);
    return (m_lim[i] == 4'd0 ? 16 : int'(m_lim[i])) * (i == 0 ? 2 : 1);
  endfunction
  function automatic bit m_rdy(int i);
    return !(m_act[i] && m_d[i] == 0);
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] <= 0; m_hold[i] <= 0; m_per[i] <= 0; m_done[i] <= 0; m_irq[i] <= 0;
        m_d[i] <= 0; m_lim[i] <= 4'd15;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        acc = cmd_valid && m_rdy(i);
        term = m_act[i] && m_d[i] == span(i);
        m_done[i] <= term && !(acc && cmd_op == 2'd2);
        m_irq[i] <= m_done[i] || (m_irq[i] && !irq_clr);
        if (acc && cmd_op == 2'd2) begin
          m_act[i] <= 0; m_hold[i] <= 0;
        end else if (acc && !cmd_op[1]) begin
          m_act[i] <= 1; m_hold[i] <= 0; m_d[i] <= 0; m_per[i] <= cmd_op[0];
        end else if (term) begin
          if (m_per[i]) m_d[i] <= 0;
          else begin m_act[i] <= 0; m_hold[i] <= 1; end
        end else if (m_act[i]) m_d[i] <= m_d[i] + 1;
        if (acc && cmd_op == 2'd3) m_lim[i] <= cmd_arg;
      end
    end
  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic tally_clear();
    for (int i = 0; i < 2; i++) begin
      en_n[i] = 0; done_n[i] = 0; nrdy_n[i] = 0; gap[i] = 0; last_done[i] = -1;
    end
  endtask
  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      if (!rst) for (int i = 0; i < 2; i++) begin
        chk($sformatf("state%0d", i), st[i], m_act[i] ? (m_d[i] == 0 ? 1 : 2) : m_hold[i] ? 3 : 0);
        chk($sformatf("cnt_en%0d", i), en[i], m_act[i] && m_d[i] > 0 && m_d[i] % (i == 0 ? 2 : 1) == 0);
        chk($sformatf("cnt_clr%0d", i), clr[i], m_act[i] && m_d[i] == 0);
        chk($sformatf("busy%0d", i), busy[i], m_act[i]);
        chk($sformatf("cmd_ready%0d", i), rdy[i], m_rdy(i));
        chk($sformatf("done%0d", i), done[i], m_done[i]);
        chk($sformatf("irq%0d", i), irq[i], IRQ ? m_irq[i] : 1'b0);
        if (en[i]) en_n[i]++;
        if (!rdy[i]) nrdy_n[i]++;
        if (done[i]) begin
          if (last_done[i] >= 0) gap[i] = cyc - last_done[i];
          last_done[i] = cyc;
          done_n[i]++;
        end
      end
    end
  endtask
  task automatic cmd(logic [1:0] op, logic [3:0] arg);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    step(1);
    cmd_valid = 1'b0;
  endtask
  initial begin
    tally_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(1);
    chk("rst_state", st[0], 0);
    chk("rst_ready", rdy[0], 1);
    // one-shot of 5 ticks
    cmd(2'd3, 4'd5);
    tally_clear();
    cmd(2'd0, 4'd0);
    step(14);
    chk("t2_ticks", en_n[0], 5);
    chk("t2_done", done_n[0], 1);
    chk("t2_hold", st[0], 3);
    chk("t2_busy", busy[0], 0);
    chk("t2_count", cnt[0], 5);
    chk("t2_ticks_p1", en_n[1], 5);
    // periodic, limit 3
    cmd(2'd3, 4'd3);
    tally_clear();
    cmd(2'd1, 4'd0);
    step(19);
    chk("t3_period", gap[0], 7);
    chk("t3_dones", done_n[0], 2);
    chk("t3_period_p1", gap[1], 4);
    cmd(2'd2, 4'd0);
    tally_clear();
    step(10);
    chk("t3_stop_ticks", en_n[0], 0);
    chk("t3_stop_done", done_n[0] + done_n[1], 0);
    chk("t3_stop_state", st[0], 0);
    // STOP on the terminal tick
    cmd(2'd3, 4'd2);
    cmd(2'd0, 4'd0);
    step(4);
    chk("t4_term_en", en[0], 1);
    chk("t4_term_cnt", cnt[0], 1);
    cmd(2'd2, 4'd0);
    chk("t4_state", st[0], 0);
    chk("t4_done", done[0], 0);
    // limit 0 wraps to 16 ticks
    cmd(2'd3, 4'd0);
    tally_clear();
    cmd(2'd0, 4'd0);
    step(40);
    chk("t5_ticks_p1", en_n[1], 16);
    chk("t5_done_p1", done_n[1], 1);
    chk("t5_notready_p1", nrdy_n[1], 1);
    chk("t5_ticks_p2", en_n[0], 16);
    // sticky irq
    chk("t6_irq_set", irq[0], IRQ);
    irq_clr = 1'b1;
    step(1);
    chk("t6_irq_cleared", irq[0], 0);
    irq_clr = 1'b0;
    cmd(2'd3, 4'd2);
    cmd(2'd0, 4'd0);
    step(5);
    chk("t6_done", done[0], 1);
    irq_clr = 1'b1;
    step(1);
    chk("t6_set_beats_clr", irq[0], IRQ);
    step(1);
    chk("t6_clr_alone", irq[0], 0);
    irq_clr = 1'b0;
    // asynchronous reset mid-run, then limit back at 15
    cmd(2'd3, 4'd9);
    cmd(2'd0, 4'd0);
    step(7);
    chk("t1_run", st[0], 2);
    chk("t1_count", cnt[0], 3);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_state", st[0], 0);
    chk("t1_async_outs", {en[0], clr[0], busy[0], done[0]}, 0);
    chk("t1_async_ready", rdy[0], 1);
    @(negedge clk);
    rst = 1'b0;
    tally_clear();
    cmd(2'd0, 4'd0);
    step(40);
    chk("t1_limit_ticks", en_n[0], 15);
    chk("t1_limit_done", done_n[0], 1);
    chk("t1_limit_ticks_p1", en_n[1], 15);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
